id_ex_forward: RTL and testbench

ID_EX_FORWARD -- requirements
Module: id_ex_forward

---
 rtl/id_ex_forward_pkg.sv | 20 ++
 rtl/id_ex_forward_if.sv | 62 ++++++
 rtl/id_ex_forward_fwd_mux.sv | 39 +++
 rtl/id_ex_forward.sv | 107 ++++++++++
 tb/tb_id_ex_forward.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_forward_pkg.sv
// Shared encodings for the ID/EX pipeline register: ALU operation codes and
// the operand forward-select values.
package id_ex_forward_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SRL = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_forward_if.sv
// Bundle of ID-stage fields, forwarding sources and EX-stage outputs around
// the ID/EX register; master drives the ID side, slave is the register.
interface id_ex_forward_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [4:0]        id_shamt;
  logic [3:0]        id_signal;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic              stall;
  logic              flush;
  logic              mem_reg_write;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic [DATA_W-1:0] ex_dataA;
  logic [DATA_W-1:0] ex_dataB;
  logic [4:0]        ex_shamt;
  logic [3:0]        ex_signal;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_write_reg;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              load_use;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_shamt, id_signal, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_alu_src, id_reg_dst, stall, flush,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  ex_dataA, ex_dataB, ex_shamt, ex_signal, ex_store_data,
           ex_write_reg, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, load_use
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_shamt, id_signal, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_alu_src, id_reg_dst, stall, flush,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output ex_dataA, ex_dataB, ex_shamt, ex_signal, ex_store_data,
           ex_write_reg, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, load_use
  );
endinterface

// File: rtl/id_ex_forward_fwd_mux.sv
// Operand bypass for one registered source specifier; the younger EX/MEM
// result beats MEM/WB, and register 0 is never bypassed.
module fwd_mux
  import id_ex_forward_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (src != '0 && mem_reg_write && mem_rd == src)
      sel = FWD_MEM;
    else if (src != '0 && wb_reg_write && wb_rd == src)
      sel = FWD_WB;
  end

  always_comb begin
    data = reg_data;
    case (sel)
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_result;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with load-use detection and combinational operand
// forwarding from the EX/MEM and MEM/WB stages.
module id_ex_forward
  import id_ex_forward_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic           clk,
  input logic           reset,
  id_ex_forward_if.slave bus
);

  logic              valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic              alu_src_q;
  logic [REG_W-1:0]  rs_q, rt_q, write_reg_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]        shamt_q;
  logic [3:0]        signal_q;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic              load_use;

  assign load_use = mem_read_q && valid_q && write_reg_q != '0 &&
                    (write_reg_q == bus.id_rs || write_reg_q == bus.id_rt) &&
                    bus.id_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      write_reg_q  <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      signal_q     <= ALU_AND;
    end else if (!bus.stall) begin
      // Datapath fields load even on a bubble; cleared controls make them inert.
      alu_src_q   <= bus.id_alu_src;
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      write_reg_q <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      rs_data_q   <= bus.id_rs_data;
      rt_data_q   <= bus.id_rt_data;
      imm_q       <= bus.id_imm;
      shamt_q     <= bus.id_shamt;
      signal_q    <= bus.id_signal;
      if (bus.flush || load_use) begin
        valid_q      <= 1'b0;
        reg_write_q  <= 1'b0;
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
      end else begin
        valid_q      <= bus.id_valid;
        reg_write_q  <= bus.id_reg_write;
        mem_read_q   <= bus.id_mem_read;
        mem_write_q  <= bus.id_mem_write;
        mem_to_reg_q <= bus.id_mem_to_reg;
      end
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src           (rs_q),
    .reg_data      (rs_data_q),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_result    (bus.mem_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_result     (bus.wb_result),
    .data          (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src           (rt_q),
    .reg_data      (rt_data_q),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_result    (bus.mem_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_result     (bus.wb_result),
    .data          (fwd_rt)
  );

  assign bus.ex_dataA      = fwd_rs;
  assign bus.ex_dataB      = alu_src_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_shamt      = shamt_q;
  assign bus.ex_signal     = signal_q;
  assign bus.ex_write_reg  = write_reg_q;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.load_use      = load_use;

endmodule

// File: tb/tb_id_ex_forward.sv
// Directed scenarios plus randomized traffic for id_ex_forward, checked
// against an instruction-level model of the EX-stage contents.
module tb_id_ex_forward;
  import id_ex_forward_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_forward_if #(.DATA_W(32), .REG_W(5)) bus ();

  id_ex_forward #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // What sits in EX: the instruction last accepted, or a bubble.
  typedef struct packed {
    logic        v, rw, mr, mw, m2r, as;
    logic [4:0]  rs, rt, wr;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  sh;
    logic [3:0]  sig;
  } ex_instr_t;

  ex_instr_t m, nxt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bypass(input logic [4:0] r, input logic [31:0] d);
    if (r == 0) return d;
    if (bus.mem_reg_write && bus.mem_rd == r) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_result;
    return d;
  endfunction

  function automatic logic hazard();
    return m.v && m.mr && m.wr != 0 && bus.id_valid &&
           (m.wr == bus.id_rs || m.wr == bus.id_rt);
  endfunction

  task automatic idle();
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_shamt = '0;
    bus.id_signal = ALU_AND; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
    bus.id_mem_write = 1'b0; bus.id_mem_to_reg = 1'b0; bus.id_alu_src = 1'b0;
    bus.id_reg_dst = 1'b0;
    bus.mem_reg_write = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
    bus.wb_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_result = '0;
  endtask

  task automatic rand_inputs();
    reset = ($urandom_range(0, 49) != 0);
    bus.stall = ($urandom_range(0, 7) == 0);
    bus.flush = ($urandom_range(0, 9) == 0);
    bus.id_valid = ($urandom_range(0, 7) != 0);
    bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
    bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_rd = 5'($urandom_range(0, 3)); bus.id_shamt = 5'($urandom);
    bus.id_signal = 4'($urandom);
    bus.id_reg_write = 1'($urandom); bus.id_mem_read = ($urandom_range(0, 2) == 0);
    bus.id_mem_write = 1'($urandom); bus.id_mem_to_reg = 1'($urandom);
    bus.id_alu_src = 1'($urandom); bus.id_reg_dst = 1'($urandom);
    bus.mem_reg_write = 1'($urandom); bus.mem_rd = 5'($urandom_range(0, 3));
    bus.mem_result = $urandom;
    bus.wb_reg_write = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 3));
    bus.wb_result = $urandom;
  endtask

  // Compare DUT against the model, then advance one clock edge.
  task automatic step();
    logic        lu;
    logic [31:0] fb;
    #1;
    lu = hazard();
    check("load_use", bus.load_use, lu);
    check("ex_valid", bus.ex_valid, m.v);
    check("ex_reg_write", bus.ex_reg_write, m.rw);
    check("ex_mem_read", bus.ex_mem_read, m.mr);
    check("ex_mem_write", bus.ex_mem_write, m.mw);
    check("ex_mem_to_reg", bus.ex_mem_to_reg, m.m2r);
    if (m.v) begin
      fb = bypass(m.rt, m.rtd);
      check("ex_dataA", bus.ex_dataA, bypass(m.rs, m.rsd));
      check("ex_dataB", bus.ex_dataB, m.as ? m.imm : fb);
      check("ex_store_data", bus.ex_store_data, fb);
      check("ex_shamt", bus.ex_shamt, m.sh);
      check("ex_signal", bus.ex_signal, m.sig);
      check("ex_write_reg", bus.ex_write_reg, m.wr);
    end
    if (!reset) nxt = '0;
    else if (bus.stall) nxt = m;
    else begin
      nxt.as = bus.id_alu_src; nxt.rs = bus.id_rs; nxt.rt = bus.id_rt;
      nxt.wr = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      nxt.rsd = bus.id_rs_data; nxt.rtd = bus.id_rt_data; nxt.imm = bus.id_imm;
      nxt.sh = bus.id_shamt; nxt.sig = bus.id_signal;
      if (bus.flush || lu) begin
        nxt.v = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0; nxt.m2r = 0;
      end else begin
        nxt.v = bus.id_valid; nxt.rw = bus.id_reg_write; nxt.mr = bus.id_mem_read;
        nxt.mw = bus.id_mem_write; nxt.m2r = bus.id_mem_to_reg;
      end
    end
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    m = '0;
    check("rst_valid", bus.ex_valid, 1'b0);
    check("rst_signal", bus.ex_signal, 4'b0000);
    check("rst_write_reg", bus.ex_write_reg, 5'd0);
    check("rst_load_use", bus.load_use, 1'b0);
    reset = 1'b1;

    // ADD with no hazards
    bus.id_valid = 1; bus.id_rs = 8; bus.id_rt = 9; bus.id_rs_data = 32'h5;
    bus.id_rt_data = 32'h3; bus.id_signal = ALU_ADD; bus.id_reg_write = 1;
    bus.id_reg_dst = 1; bus.id_rd = 10;
    step();
    idle();
    #1;
    check("add_dataA", bus.ex_dataA, 32'h5);
    check("add_dataB", bus.ex_dataB, 32'h3);
    check("add_signal", bus.ex_signal, 4'b0010);
    check("add_valid", bus.ex_valid, 1'b1);

    // EX/MEM beats MEM/WB on the same register
    bus.id_valid = 1; bus.id_rs = 8; bus.id_rs_data = 32'h1234;
    step();
    idle();
    bus.mem_reg_write = 1; bus.mem_rd = 8; bus.mem_result = 32'h11;
    bus.wb_reg_write = 1; bus.wb_rd = 8; bus.wb_result = 32'h22;
    #1;
    check("fwd_mem_wins", bus.ex_dataA, 32'h11);
    bus.mem_reg_write = 0;
    #1;
    check("fwd_wb", bus.ex_dataA, 32'h22);

    // register 0 is never bypassed
    idle();
    bus.id_valid = 1; bus.id_rs = 0; bus.id_rs_data = 32'h0;
    step();
    idle();
    bus.mem_reg_write = 1; bus.mem_rd = 0; bus.mem_result = 32'hFF;
    #1;
    check("zero_reg", bus.ex_dataA, 32'h0);

    // lw $t0 followed by a reader of $t0
    idle();
    bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_mem_to_reg = 1;
    bus.id_alu_src = 1; bus.id_rt = 8; bus.id_reg_dst = 0;
    step();
    idle();
    bus.id_valid = 1; bus.id_rs = 8; bus.id_rt = 3; bus.id_reg_write = 1;
    bus.id_reg_dst = 1; bus.id_rd = 4; bus.id_signal = ALU_ADD;
    #1;
    check("lu_high", bus.load_use, 1'b1);
    step();
    check("lu_bubble_valid", bus.ex_valid, 1'b0);
    check("lu_bubble_rw", bus.ex_reg_write, 1'b0);
    check("lu_fall", bus.load_use, 1'b0);

    // stall overrides flush, then flush takes effect
    idle();
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rs = 1; bus.id_rs_data = 32'hAA;
    bus.id_signal = ALU_OR;
    step();
    bus.stall = 1; bus.flush = 1;
    step();
    step();
    check("stall_valid", bus.ex_valid, 1'b1);
    check("stall_rw", bus.ex_reg_write, 1'b1);
    check("stall_dataA", bus.ex_dataA, 32'hAA);
    bus.stall = 0;
    step();
    check("flush_bubble", bus.ex_valid, 1'b0);

    // reset wins over stall
    idle();
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_reg_dst = 1; bus.id_rd = 7;
    bus.id_signal = ALU_SUB;
    step();
    bus.stall = 1; reset = 0;
    step();
    check("rst_stall_valid", bus.ex_valid, 1'b0);
    check("rst_stall_rw", bus.ex_reg_write, 1'b0);
    check("rst_stall_signal", bus.ex_signal, 4'b0000);
    check("rst_stall_wr", bus.ex_write_reg, 5'd0);

    // sw: immediate feeds ALU, forwarded rt feeds store data
    idle();
    bus.id_valid = 1; bus.id_mem_write = 1; bus.id_alu_src = 1; bus.id_rs = 2;
    bus.id_rt = 5; bus.id_rt_data = 32'h100; bus.id_imm = 32'h40; bus.id_signal = ALU_ADD;
    step();
    idle();
    bus.wb_reg_write = 1; bus.wb_rd = 5; bus.wb_result = 32'h7;
    #1;
    check("sw_dataB_imm", bus.ex_dataB, 32'h40);
    check("sw_store_fwd", bus.ex_store_data, 32'h7);

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
